dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder: the target end of the CPU's load/store interface. It accepts one load or store request at a time over a valid/ready handshake and performs byte, half or word access to a local word array. After a fixed programmable latency it returns sign- or zero-extended load data, or an error flag. Sits behind the CPU memory stage, replacing the zero-latency `mem` model so the pipeline can be exercised against real stalls.

Parameters:
ADDR_W, 10, word-address width; array depth = 2**ADDR_W words (4 KiB at default)
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
req_is_store  in  1  1=store, 0=load
req_type  in  3  funct3 access type (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data; low byte/half used for SB/SH
resp_valid  out  1  response present
resp_ready  in  1  initiator accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal type or out-of-range access

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; req_ready=0 while rst=1. Array contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP. req_ready=1 only in IDLE (registered state, no combinational path from req_valid).
- IDLE: on req_valid&&req_ready, capture is_store, type, addr and wdata, and load the counter with LATENCY-1. Go to RESP if LATENCY=1, otherwise WAIT.
- WAIT: decrement the counter each cycle; on reaching 0, go to RESP. resp_valid rises exactly LATENCY cycles after the accept cycle.
- The error check is computed at acceptance from captured fields. err=1 if:
  - the type is illegal (load 011/110/111; store anything except 000/001/010), or
  - a half access has addr[0]=1, or
  - a word access has addr[1:0]!=0, or
  - any addr bit above ADDR_W+1 is set.
- Store write: performed once, on the cycle the FSM enters RESP, with byte enables from type and addr[1:0], little-endian. No write if err.
- Load read: on entry to RESP, register the extended result:
  - LB/LH sign-extend from the selected byte/half lane.
  - LBU/LHU zero-extend.
  - LW takes the full word.
  - Store or err gives resp_rdata=0.
- RESP: resp_valid=1; resp_rdata and resp_err hold stable until resp_valid&&resp_ready. The FSM then returns to IDLE, with req_ready=1 on the next cycle. Minimum request spacing is LATENCY+1 cycles.
- req_valid during WAIT/RESP is ignored (not accepted, not lost by the responder — the initiator holds it).
- A load issued after a store's response sees the stored data.
- rst in WAIT or RESP: state returns to IDLE next cycle, resp_valid drops, and any pending store that has not yet been written is discarded.

Decomposition:
- Shared package mem_pkg: funct3 constants (MEM_B=000, MEM_H=001, MEM_W=010, MEM_BU=100, MEM_HU=101), FSM state enum, and a function computing byte-enable from type and offset.
- One sub-module, dmem_array: synchronous single-port 32-bit RAM with 4-bit byte-enable write and a registered read.
- FSM, counter, error check and extension logic stay in dmem_responder.

Test Plan:
1. SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 → rdata 0xDEADBEEF, err=0; resp_valid exactly LATENCY cycles after each accept.
2. SB 0x11 wdata 0x80 → LW 0x10 returns 0xDEAD80EF; LB 0x11 returns 0xFFFFFF80; LBU 0x11 returns 0x00000080.
3. SH 0x12 wdata 0x8001, then:
   - LH 0x12 → 0xFFFF8001.
   - LHU 0x12 → 0x00008001.
   - LW 0x13 → err=1, rdata=0.
   - SH 0x11 → err=1, memory unchanged.
4. Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 → resp_valid, rdata and err stable; req_ready=0; no second accept until the cycle after the response handshake.
5. Reset during WAIT of SW 0x20 0x12345678 (LATENCY=3) → resp_valid=0 next cycle; a later LW 0x20 returns the prior contents.
6. With ADDR_W=10, LW 0x00001000 and a load with type 011 → both err=1, rdata=0; LATENCY=1 build gives resp_valid one cycle after accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared load/store definitions: funct3 access codes, FSM states, request payload and lane helpers.
package mem_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned BE_W  = 4;
   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic            is_store;
      logic [2:0]      mtype;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } mem_req_t;

   // Little-endian byte enables for a store of the given size at the given offset.
   function automatic logic [BE_W-1:0] byte_en(input logic [2:0] mtype, input logic [1:0] off);
      case (mtype)
         MEM_B:   byte_en = 4'b0001 << off;
         MEM_H:   byte_en = 4'b0011 << off;
         MEM_W:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

   // Replicate store data across lanes so the byte enables pick the right copy.
   function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] mtype, input logic [XLEN-1:0] wdata);
      case (mtype)
         MEM_B:   store_lanes = {4{wdata[7:0]}};
         MEM_H:   store_lanes = {2{wdata[15:0]}};
         default: store_lanes = wdata;
      endcase
   endfunction

   // Select the addressed lane of a word and sign- or zero-extend it.
   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] mtype, input logic [1:0] off,
                                                input logic [XLEN-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      case (mtype)
         MEM_B:   load_ext = {{24{b[7]}}, b};
         MEM_BU:  load_ext = {24'h0, b};
         MEM_H:   load_ext = {{16{h[15]}}, h};
         MEM_HU:  load_ext = {16'h0, h};
         MEM_W:   load_ext = word;
         default: load_ext = '0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the CPU memory stage and the responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_is_store, req_type, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_is_store, req_type, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rd_en_i,
   input  logic [3:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Byte-masked write and registered read; contents are never reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      if (rd_en_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one outstanding load/store, fixed response latency, sized and extended access.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_req_t          req_q, req_d;
   logic              err_q, err_d;

   mem_req_t          bus_req_c, cur_c;
   logic              bus_err_c, cur_err_c;
   logic              idle_c, req_ready_c, accept_c, enter_resp_c, resp_c, ram_rd_c;
   logic [BE_W-1:0]   ram_be_c;
   logic [XLEN-1:0]   ram_rdata;

   // Illegal type, misalignment or an address beyond the array.
   function automatic logic calc_err(input mem_req_t r);
      logic bad_type, misal, oor;
      if (r.is_store) bad_type = !(r.mtype inside {MEM_B, MEM_H, MEM_W});
      else            bad_type = !(r.mtype inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});
      misal = ((r.mtype[1:0] == 2'b01) && r.addr[0]) ||
              ((r.mtype[1:0] == 2'b10) && (r.addr[1:0] != 2'b00));
      oor   = (r.addr >> (ADDR_W + 2)) != 32'd0;
      return bad_type || misal || oor;
   endfunction

   // Request fields as presented on the bus, and the error they would raise.
   always_comb begin
      bus_req_c.is_store = bus.req_is_store;
      bus_req_c.mtype    = bus.req_type;
      bus_req_c.addr     = bus.req_addr;
      bus_req_c.wdata    = bus.req_wdata;
      bus_err_c          = calc_err(bus_req_c);
   end

   assign idle_c      = (state_q == S_IDLE);
   assign req_ready_c = idle_c && !rst;
   assign accept_c    = bus.req_valid && req_ready_c;
   assign resp_c      = (state_q == S_RESP);

   // State register with synchronous reset; a reset in WAIT drops the captured request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end

   // Next state: capture on accept, count down the latency, hold the response until taken.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               req_d   = bus_req_c;
               err_d   = bus_err_c;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (bus.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The array is touched once, on the edge that enters RESP; with LATENCY=1 that is the accept edge.
   always_comb begin
      cur_c        = idle_c ? bus_req_c : req_q;
      cur_err_c    = idle_c ? bus_err_c : err_q;
      enter_resp_c = !rst && (state_d == S_RESP) && !resp_c;
      ram_be_c     = (enter_resp_c && cur_c.is_store && !cur_err_c) ?
                     byte_en(cur_c.mtype, cur_c.addr[1:0]) : '0;
      ram_rd_c     = enter_resp_c && !cur_c.is_store && !cur_err_c;
   end

   dmem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk_i   (clk),
      .rd_en_i (ram_rd_c),
      .be_i    (ram_be_c),
      .addr_i  (cur_c.addr[ADDR_W+1:2]),
      .wdata_i (store_lanes(cur_c.mtype, cur_c.wdata)),
      .rdata_o (ram_rdata)
   );

   // Responses come straight from registered state; the RAM word is held until the next access.
   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = resp_c;
   assign bus.resp_err   = resp_c && err_q;
   assign bus.resp_rdata = (resp_c && !err_q && !req_q.is_store) ?
                           load_ext(req_q.mtype, req_q.addr[1:0], ram_rdata) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (LATENCY 1, 2, 3) with a scoreboard of expected responses.
module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_v [3];
   logic        rv    [3];
   logic        st    [3];
   logic [2:0]  ty    [3];
   logic [31:0] ad    [3];
   logic [31:0] wd    [3];
   logic        rr    [3];
   logic        rdy   [3];
   logic        vld   [3];
   logic        rerr  [3];
   logic [31:0] rd    [3];

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // Index g runs a build with LATENCY = g+1.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder_if bus ();
      assign bus.req_valid    = rv[g];
      assign bus.req_is_store = st[g];
      assign bus.req_type     = ty[g];
      assign bus.req_addr     = ad[g];
      assign bus.req_wdata    = wd[g];
      assign bus.resp_ready   = rr[g];
      assign rdy[g]  = bus.req_ready;
      assign vld[g]  = bus.resp_valid;
      assign rerr[g] = bus.resp_err;
      assign rd[g]   = bus.resp_rdata;
      dmem_responder #(.ADDR_W(10), .LATENCY(g + 1)) u_dut (
         .clk (clk),
         .rst (rst_v[g]),
         .bus (bus)
      );
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Issue one request, check latency against the build, then compare the response with the scoreboard.
   task automatic do_txn(input int s, input logic is_st, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] exp_rd, input logic exp_err,
                         input string name);
      exp_t e;
      int   n;
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb_q.push_back(e);
      rv[s] = 1'b1; st[s] = is_st; ty[s] = t; ad[s] = a; wd[s] = w; rr[s] = 1'b1;
      n = 0;
      while (!rdy[s] && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (rdy[s] !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b want 1", name, rdy[s]);
         rv[s] = 1'b0;
         void'(sb_q.pop_front());
         return;
      end
      @(posedge clk); #1;
      rv[s] = 1'b0;
      n = 1;
      while (vld[s] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (vld[s] !== 1'b1 || n != s + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, n, s + 1);
      end
      if (vld[s] !== 1'b1) begin
         void'(sb_q.pop_front());
         return;
      end
      e = sb_q.pop_front();
      checks++;
      if (rd[s] !== e.rdata) begin
         errors++;
         $display("FAIL %s rdata: got %h want %h", name, rd[s], e.rdata);
      end
      checks++;
      if (rerr[s] !== e.err) begin
         errors++;
         $display("FAIL %s err: got %b want %b", name, rerr[s], e.err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         rst_v[s] = 1'b1; rv[s] = 1'b0; st[s] = 1'b0; ty[s] = 3'b010;
         ad[s] = '0; wd[s] = '0; rr[s] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (rdy[s] !== 1'b0 || vld[s] !== 1'b0 || rerr[s] !== 1'b0 || rd[s] !== 32'h0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got rdy=%b vld=%b err=%b rdata=%h want 0 0 0 0",
                     s, rdy[s], vld[s], rerr[s], rd[s]);
         end
      end
      for (int s = 0; s < 3; s++) rst_v[s] = 1'b0;
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (rdy[s] !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready[%0d]: got %b want 1", s, rdy[s]);
         end
      end
   endtask

   task automatic test_word();
      do_txn(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_0x10");
      do_txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_0x10");
   endtask

   task automatic test_byte();
      do_txn(1, 1'b1, 3'b000, 32'h11, 32'h00000080, 32'h0, 1'b0, "sb_0x11");
      do_txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0, "lw_after_sb");
      do_txn(1, 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, "lb_0x11");
      do_txn(1, 1'b0, 3'b100, 32'h11, 32'h0, 32'h00000080, 1'b0, "lbu_0x11");
   endtask

   task automatic test_half();
      do_txn(1, 1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 1'b0, "sh_0x12");
      do_txn(1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, "lh_0x12");
      do_txn(1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0, "lhu_0x12");
      do_txn(1, 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, "lw_misaligned");
      do_txn(1, 1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0, 1'b1, "sh_misaligned");
      do_txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h800180EF, 1'b0, "lw_after_bad_sh");
   endtask

   task automatic test_errors();
      do_txn(1, 1'b0, 3'b010, 32'h00001000, 32'h0, 32'h0, 1'b1, "lw_out_of_range");
      do_txn(1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "load_type_011");
      do_txn(1, 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, "load_type_110");
      do_txn(1, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, "store_type_100");
      do_txn(1, 1'b0, 3'b101, 32'h13, 32'h0, 32'h0, 1'b1, "lhu_odd");
      do_txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h800180EF, 1'b0, "lw_after_bad_store");
      do_txn(1, 1'b1, 3'b010, 32'h0FFC, 32'h11223344, 32'h0, 1'b0, "sw_top_word");
      do_txn(1, 1'b0, 3'b010, 32'h0FFC, 32'h0, 32'h11223344, 1'b0, "lw_top_word");
   endtask

   // Stall the response with a second request waiting; nothing may move until the handshake.
   task automatic test_backpressure();
      exp_t e;
      int   n;
      e.rdata = 32'h800180EF;
      e.err   = 1'b0;
      sb_q.push_back(e);
      rv[1] = 1'b1; st[1] = 1'b0; ty[1] = 3'b010; ad[1] = 32'h10; wd[1] = '0; rr[1] = 1'b0;
      n = 0;
      while (!rdy[1] && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      ad[1] = 32'h0FFC;
      n = 1;
      while (vld[1] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (vld[1] !== 1'b1 || n != 2) begin
         errors++;
         $display("FAIL bp_latency: got %0d want 2", n);
      end
      e = sb_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (vld[1] !== 1'b1 || rd[1] !== e.rdata || rerr[1] !== e.err || rdy[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdata=%h err=%b rdy=%b want 1 %h %b 0",
                     i, vld[1], rd[1], rerr[1], rdy[1], e.rdata, e.err);
         end
         @(posedge clk); #1;
      end
      rr[1] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (vld[1] !== 1'b0 || rdy[1] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", vld[1], rdy[1]);
      end
      do_txn(1, 1'b0, 3'b010, 32'h0FFC, 32'h0, 32'h11223344, 1'b0, "bp_second_req");
   endtask

   // Reset the LATENCY=3 build while a store waits; the store must never land.
   task automatic test_reset_in_wait();
      do_txn(2, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "l3_sw_prior");
      rv[2] = 1'b1; st[2] = 1'b1; ty[2] = 3'b010; ad[2] = 32'h20; wd[2] = 32'h12345678; rr[2] = 1'b1;
      @(posedge clk); #1;
      rv[2] = 1'b0;
      rst_v[2] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (vld[2] !== 1'b0 || rdy[2] !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait: got vld=%b rdy=%b want 0 0", vld[2], rdy[2]);
      end
      rst_v[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (vld[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_resp[%0d]: got vld=%b want 0", i, vld[2]);
         end
      end
      do_txn(2, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "l3_lw_after_rst");
   endtask

   task automatic test_back_to_back();
      do_txn(0, 1'b1, 3'b010, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, "l1_sw");
      do_txn(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, "l1_lw");
      do_txn(0, 1'b1, 3'b000, 32'h3, 32'h0000007F, 32'h0, 1'b0, "l1_sb");
      do_txn(0, 1'b0, 3'b000, 32'h3, 32'h0, 32'h0000007F, 1'b0, "l1_lb");
      do_txn(0, 1'b0, 3'b101, 32'h2, 32'h0, 32'h00007FA5, 1'b0, "l1_lhu");
      do_txn(0, 1'b0, 3'b010, 32'h00001000, 32'h0, 32'h0, 1'b1, "l1_lw_oor");
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_backpressure();
      test_reset_in_wait();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
